context_encoder_updater: RTL and testbench
==========================================

Name: context_encoder_updater

Overview:
- Encoder-side counterpart of the entropy decoder's context updater, in the LiDAR encoder's entropy-coding path.
- Accepts a symbol stream and tags each symbol with the context under which it must be arithmetic-coded. It then advances the context through a runtime-programmable transition table indexed by {symbol, context}, the same indexing the decoder uses.
- It owns the table: it clears the table after reset and accepts a configuration load before streaming starts. Encoder and decoder therefore track contexts identically.

Parameters:
- SYM_BITS, 4, symbol LSBs used for the table index.
- CTX_BITS, 4, context LSBs used for the table index.
- INIT_CTX, 16'h0000, context after reset, after table clear, and at frame start.

Ports:
- clk  input  1  clock; all state on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  request to (re)enter table load.
- cfg_we  input  1  table write strobe.
- cfg_addr  input  SYM_BITS+CTX_BITS  table index; symbol field in the upper bits, context field in the lower bits.
- cfg_wdata  input  16  next-context value.
- cfg_done  input  1  ends the table load.
- cfg_err  output  1  one-cycle pulse when a cfg_we is dropped.
- table_ready  output  1  high in RUN only.
- sym_valid  input  1  symbol offered.
- sym_ready  output  1  symbol accepted when valid and ready are both high.
- sym_data  input  16  symbol.
- sym_last  input  1  last symbol of the frame.
- out_valid  output  1  encoder-side output valid.
- out_ready  input  1  downstream ready.
- out_symbol  output  16  registered symbol.
- out_context  output  16  context to code out_symbol with.
- out_last  output  1  registered sym_last.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to CLEAR; clear counter = 0; ctx_q = INIT_CTX.
  - Outputs: out_valid=0, out_symbol=0, out_context=0, out_last=0, cfg_err=0, table_ready=0, sym_ready=0.
  - Table contents are not reset directly; CLEAR overwrites them.
  - Reset mid-stream discards the in-flight output word and restarts CLEAR.
- State machine, with states CLEAR, LOAD, RUN, DRAIN:
  - CLEAR: writes INIT_CTX to table[cnt] each cycle, cnt = 0 .. 2^(SYM_BITS+CTX_BITS)-1. That is 256 cycles at the defaults. Then goes to LOAD.
    - cfg_we is ignored in CLEAR and pulses cfg_err the next cycle.
  - LOAD: each cfg_we writes cfg_wdata to table[cfg_addr] at that edge. Later writes to the same address overwrite earlier ones.
    - On cfg_done, goes to RUN and sets ctx_q = INIT_CTX.
    - If cfg_we and cfg_done are high in the same cycle, the write lands before the RUN transition.
  - RUN: table_ready=1. sym_ready = !out_valid || out_ready.
    - cfg_we is dropped with a cfg_err pulse.
    - On cfg_start, goes to DRAIN. sym_ready is 0 from the next cycle.
  - DRAIN: waits until out_valid=0, then goes to LOAD. The table is kept, not re-cleared.
- Per-symbol operation on acceptance (sym_valid and sym_ready both high):
  - Next edge: out_symbol=sym_data, out_context=ctx_q (the pre-update context, mirroring the decoder), out_last=sym_last, out_valid=1.
  - Same edge, context update:
    - If sym_last is high, ctx_q = INIT_CTX.
    - Otherwise, ctx_q = table[{sym_data[SYM_BITS-1:0], ctx_q[CTX_BITS-1:0]}].
  - Only the low index bits are used. Upper symbol and context bits never make an access invalid.
- Timing:
  - Latency: 1 cycle from acceptance to out_valid.
  - Full throughput of 1 symbol per cycle while out_ready=1.
  - The table read is asynchronous (combinational); a single write port is shared by CLEAR and LOAD.
- Output handshake:
  - out_valid with out_ready high and no new acceptance: out_valid goes to 0.
  - While out_ready=0, the output registers and ctx_q hold and sym_ready=0.
  - Acceptance and output drain in the same cycle: the new word replaces the old one; out_valid stays 1.
- Boundary: the context wraps naturally through table values. No saturation or range check is applied.

Test Plan:
- Release reset, no cfg activity -> table_ready rises after exactly 256+1 cycles (CLEAR plus one LOAD cycle, with cfg_done held high); symbols 3,5,7 with out_ready=1 -> out_context = 0,0,0.
- Load table[{4'h3,4'h0}]=16'h0012 and table[{4'h5,4'h2}]=16'h00A7, then cfg_done; send 3,5,9 -> out_context = 0000, 0012, 00A7.
- Same table as the previous scenario; send 3 with sym_last=1, then 5 -> out_context = 0000, 0000 (frame restart); out_last=1 on the first word only.
- Streaming with out_ready low for 3 cycles mid-stream -> sym_ready=0, out_symbol/out_context/ctx_q stable, no symbol lost or duplicated; back-to-back throughput resumes at 1 symbol per cycle.
- cfg_we during RUN -> cfg_err pulses for one cycle and the table is unchanged; cfg_start with out_valid=1 and out_ready=0 -> stays in DRAIN until the word is taken, then LOAD (table_ready=0).
- Assert reset_n low during streaming -> out_valid=0 and table_ready=0 immediately (asynchronous); CLEAR restarts and the previously loaded entries read as INIT_CTX afterwards.

Source files
------------

// File: rtl/context_encoder_updater.sv
// rtl/context_encoder_updater.sv - tags symbols with their coding context and advances it through a programmable table
module context_encoder_updater #(
  parameter int          SYM_BITS = 4,
  parameter int          CTX_BITS = 4,
  parameter logic [15:0] INIT_CTX = 16'h0000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cfg_start,
  input  logic                         cfg_we,
  input  logic [SYM_BITS+CTX_BITS-1:0] cfg_addr,
  input  logic [15:0]                  cfg_wdata,
  input  logic                         cfg_done,
  output logic                         cfg_err,
  output logic                         table_ready,
  input  logic                         sym_valid,
  output logic                         sym_ready,
  input  logic [15:0]                  sym_data,
  input  logic                         sym_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  out_symbol,
  output logic [15:0]                  out_context,
  output logic                         out_last
);

  localparam int ADDR_BITS = SYM_BITS + CTX_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clr_cnt_q;
  logic [15:0]            ctx_q;
  logic [15:0]            ctx_table [DEPTH];
  logic                   tbl_we;
  logic [ADDR_BITS-1:0]   tbl_waddr;
  logic [15:0]            tbl_wdata;
  logic                   accept;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [15:0]            ctx_next;

  assign table_ready = (state_q == RUN);
  assign sym_ready   = table_ready && (!out_valid || out_ready);
  assign accept      = sym_valid && sym_ready;
  // Same {symbol, context} low-bit index the decoder uses, so both sides track identically
  assign rd_addr     = {sym_data[SYM_BITS-1:0], ctx_q[CTX_BITS-1:0]};
  assign ctx_next    = sym_last ? INIT_CTX : ctx_table[rd_addr];

  always_comb begin
    state_d   = state_q;
    tbl_we    = 1'b0;
    tbl_waddr = cfg_addr;
    tbl_wdata = cfg_wdata;
    case (state_q)
      CLEAR: begin
        tbl_we    = 1'b1;
        tbl_waddr = clr_cnt_q;
        tbl_wdata = INIT_CTX;
        if (&clr_cnt_q) state_d = LOAD;
      end
      LOAD: begin
        tbl_we = cfg_we;
        if (cfg_done) state_d = RUN;
      end
      RUN: begin
        if (cfg_start) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_valid) state_d = LOAD;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Single write port shared by CLEAR and LOAD; contents survive reset until CLEAR overwrites them
  always_ff @(posedge clk) begin
    if (tbl_we) ctx_table[tbl_waddr] <= tbl_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      ctx_q       <= INIT_CTX;
      cfg_err     <= 1'b0;
      out_valid   <= 1'b0;
      out_symbol  <= '0;
      out_context <= '0;
      out_last    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= (state_q == CLEAR) ? clr_cnt_q + ADDR_BITS'(1) : '0;
      cfg_err   <= cfg_we && (state_q != LOAD);
      if (state_q == LOAD && cfg_done) begin
        ctx_q <= INIT_CTX;
      end else if (accept) begin
        ctx_q <= ctx_next;
      end
      if (accept) begin
        out_valid   <= 1'b1;
        out_symbol  <= sym_data;
        out_context <= ctx_q;
        out_last    <= sym_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_context_encoder_updater.sv
// tb/tb_context_encoder_updater.sv - directed self-checking bench for context_encoder_updater
module tb_context_encoder_updater;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_start, cfg_we, cfg_done;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_err, table_ready;
  logic        sym_valid, sym_ready, sym_last;
  logic [15:0] sym_data;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_symbol, out_context;

  int checks = 0;
  int errors = 0;

  logic [15:0] got_sym[$], got_ctx[$];
  logic        got_last[$];
  logic [15:0] exp_sym[$], exp_ctx[$];
  logic        exp_last[$];

  context_encoder_updater dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start(cfg_start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .table_ready(table_ready),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_symbol(out_symbol),
    .out_context(out_context), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      got_sym.push_back(out_symbol);
      got_ctx.push_back(out_context);
      got_last.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic [15:0] s, input logic [15:0] c, input logic l);
    exp_sym.push_back(s);
    exp_ctx.push_back(c);
    exp_last.push_back(l);
  endtask

  task automatic clear_words();
    got_sym.delete(); got_ctx.delete(); got_last.delete();
    exp_sym.delete(); exp_ctx.delete(); exp_last.delete();
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, got_sym.size(), exp_sym.size());
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      check($sformatf("%s_sym%0d", tag, i), got_sym[i], exp_sym[i]);
      check($sformatf("%s_ctx%0d", tag, i), got_ctx[i], exp_ctx[i]);
      check($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
    end
    clear_words();
  endtask

  task automatic send(input logic [15:0] s, input logic l);
    logic acc;
    int   n;
    sym_valid = 1'b1;
    sym_data  = s;
    sym_last  = l;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = sym_ready;
      step();
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    sym_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!table_ready && n < 400) begin
      step();
      n++;
    end
    check(tag, n, 257);
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic finish_load();
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    check("load_table_ready", table_ready, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_start = 0; cfg_we = 0; cfg_done = 0; cfg_addr = 0; cfg_wdata = 0;
    sym_valid = 0; sym_data = 0; sym_last = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_table_ready", table_ready, 0);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_out_symbol", out_symbol, 0);
    check("rst_out_context", out_context, 0);

    // Clear then a single LOAD cycle with cfg_done held
    reset_n = 1'b1;
    cfg_done = 1'b1;
    wait_ready("clear_cycles");
    cfg_done = 1'b0;
    clear_words();
    send(3, 0); send(5, 0); send(7, 0);
    repeat (2) step();
    exp_word(3, 0, 0); exp_word(5, 0, 0); exp_word(7, 0, 0);
    compare_words("cleared");

    // Reload table
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    check("drain_table_ready", table_ready, 0);
    repeat (2) step();
    cfg_write(8'h30, 16'h0012);
    cfg_write(8'h52, 16'h00A7);
    finish_load();
    send(3, 0); send(5, 0); send(9, 0);
    repeat (2) step();
    exp_word(3, 16'h0000, 0); exp_word(5, 16'h0012, 0); exp_word(9, 16'h00A7, 0);
    compare_words("table");

    // Frame restart on sym_last
    send(3, 1); send(5, 0);
    repeat (2) step();
    exp_word(3, 0, 1); exp_word(5, 0, 0);
    compare_words("frame");

    // Back-pressure mid-stream
    out_ready = 1'b1; sym_valid = 1'b1; sym_data = 3; sym_last = 0;
    #1 check("stall_rdy0", sym_ready, 1);
    step();
    out_ready = 1'b0; sym_data = 5;
    #1 check("stall_rdy_low", sym_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", out_valid, 1);
      check("stall_sym", out_symbol, 3);
      check("stall_ctx", out_context, 0);
      check("stall_sym_ready", sym_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("resume_rdy1", sym_ready, 1);
    step();
    sym_data = 9;
    #1 check("resume_rdy2", sym_ready, 1);
    step();
    sym_valid = 1'b0;
    repeat (2) step();
    exp_word(3, 0, 0); exp_word(5, 16'h0012, 0); exp_word(9, 16'h00A7, 0);
    compare_words("stall");

    // Dropped write in RUN
    cfg_we = 1'b1; cfg_addr = 8'h30; cfg_wdata = 16'h0055;
    step();
    cfg_we = 1'b0;
    check("run_cfg_err_pulse", cfg_err, 1);
    step();
    check("run_cfg_err_clear", cfg_err, 0);
    send(3, 0); send(5, 1);
    repeat (2) step();
    exp_word(3, 0, 0); exp_word(5, 16'h0012, 1);
    compare_words("run_we");

    // DRAIN holds until the pending word is taken
    out_ready = 1'b0;
    send(7, 0);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    check("drain_tr", table_ready, 0);
    check("drain_sr", sym_ready, 0);
    repeat (2) step();
    check("drain_hold_valid", out_valid, 1);
    check("drain_hold_sym", out_symbol, 7);
    out_ready = 1'b1;
    step();
    check("drain_taken", out_valid, 0);
    step();
    cfg_write(8'h00, 16'h0002);
    check("load_no_err", cfg_err, 0);
    finish_load();
    clear_words();
    send(0, 0); send(5, 0); send(9, 1);
    repeat (2) step();
    exp_word(0, 0, 0); exp_word(5, 16'h0002, 0); exp_word(9, 16'h00A7, 1);
    compare_words("kept");

    // Asynchronous reset while a word is in flight
    out_ready = 1'b0;
    send(3, 0);
    check("pre_rst_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_table_ready", table_ready, 0);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    cfg_done = 1'b1;
    wait_ready("reclear_cycles");
    cfg_done = 1'b0;
    clear_words();
    send(0, 0); send(5, 0); send(3, 0);
    repeat (2) step();
    exp_word(0, 0, 0); exp_word(5, 0, 0); exp_word(3, 0, 0);
    compare_words("reclear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
